// File: rtl/riscv_nn_apu_arb_pkg.sv
// Shared types and defaults for the APU arbiter and its response tag FIFO.
package riscv_nn_apu_arb_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned OP_W_DEF  = 32;

    // Tag storage is sized for the largest supported requester count (8).
    localparam int unsigned ID_W_MAX  = 3;

    typedef logic [ID_W_MAX-1:0] req_id_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/riscv_nn_apu_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per request accepted by the APU.
module riscv_nn_apu_tag_fifo
    import riscv_nn_apu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  req_id_t                    id_i,
    input  logic                       pop_i,
    output req_id_t                    id_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    req_id_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt == CNT_W'(DEPTH));
    assign empty_o = (cnt == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign id_o    = mem[rd_ptr];
    assign count_o = cnt;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= id_i;
        end
    end

    // Pointers wrap naturally; the count alone distinguishes full from empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/riscv_nn_apu_arbiter.sv
// Round-robin sharing of one APU port among NREQ dispatchers, with in-order
// routing of response valids back to the requester that issued each request.
module riscv_nn_apu_arbiter
    import riscv_nn_apu_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned OP_W  = OP_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*OP_W-1:0]     op_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          valid_o,
    output logic                     apu_req_o,
    output logic [OP_W-1:0]          apu_op_o,
    input  logic                     apu_gnt_i,
    input  logic                     apu_valid_i,
    output logic                     apu_ready_o,
    output logic [$clog2(DEPTH):0]   outstanding_o,
    output logic                     err_o
);

    localparam int unsigned ID_W = id_width(NREQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic            found_hi;
    logic            found_lo;
    logic            found;
    logic            full;
    logic            empty;
    logic            accept;
    logic            pop;
    req_id_t         head_id;

    // Rotating priority: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_lo   = ID_W'(k);
                found_lo = 1'b1;
                if (ID_W'(k) >= ptr) begin
                    win_hi   = ID_W'(k);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign found  = found_lo && !full;
    assign winner = found_hi ? win_hi : win_lo;

    always_comb begin
        apu_op_o = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (found && (winner == ID_W'(k))) begin
                apu_op_o = op_i[k*OP_W +: OP_W];
            end
        end
    end

    assign apu_req_o   = found;
    assign accept      = apu_req_o && apu_gnt_i;
    assign gnt_o       = accept ? (NREQ'(1) << winner) : '0;
    assign pop         = apu_valid_i && !empty;
    assign valid_o     = pop ? (NREQ'(1) << head_id) : '0;
    assign apu_ready_o = 1'b1;

    riscv_nn_apu_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .id_i    (req_id_t'(winner)),
        .pop_i   (pop),
        .id_o    (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    // A stalled winner keeps priority; the pointer only moves past an accepted requester.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr   <= '0;
            err_o <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
            end
            if (apu_valid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_nn_apu_arbiter.sv
// Directed vector bench for riscv_nn_apu_arbiter at NREQ=4, DEPTH=4, OP_W=32.
module tb_riscv_nn_apu_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OP_W  = 32;
    localparam int          NVEC  = 28;
    localparam int          NHAND = 8;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       gnt;
        logic       val;
        logic [3:0] e_gnt;
        logic [3:0] e_val;
        logic       e_req;
        logic [2:0] e_out;
        logic       e_err;
        int         e_win;
    } vec_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*OP_W-1:0] op_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      valid_o;
    logic                 apu_req_o;
    logic [OP_W-1:0]      apu_op_o;
    logic                 apu_gnt_i;
    logic                 apu_valid_i;
    logic                 apu_ready_o;
    logic [2:0]           outstanding_o;
    logic                 err_o;

    int tests  = 0;
    int failed = 0;

    vec_t tbl  [NVEC];
    vec_t hand [NHAND];

    riscv_nn_apu_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH),
        .OP_W  (OP_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .op_i          (op_i),
        .gnt_o         (gnt_o),
        .valid_o       (valid_o),
        .apu_req_o     (apu_req_o),
        .apu_op_o      (apu_op_o),
        .apu_gnt_i     (apu_gnt_i),
        .apu_valid_i   (apu_valid_i),
        .apu_ready_o   (apu_ready_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t v(input logic rst, input logic [3:0] req, input logic gnt,
                               input logic val, input logic [3:0] e_gnt, input logic [3:0] e_val,
                               input logic e_req, input logic [2:0] e_out, input logic e_err,
                               input int e_win);
        vec_t r;
        r.rst = rst;     r.req = req;     r.gnt = gnt;     r.val = val;
        r.e_gnt = e_gnt; r.e_val = e_val; r.e_req = e_req; r.e_out = e_out;
        r.e_err = e_err; r.e_win = e_win;
        return r;
    endfunction

    function automatic logic [OP_W-1:0] op_of(input int k);
        return (k < 0) ? '0 : 32'hA000_0000 + 32'(k);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check outputs before the rising edge.
    task automatic apply(input vec_t t, input int idx);
        @(negedge clk_i);
        rst_i       = t.rst;
        req_i       = t.req;
        apu_gnt_i   = t.gnt;
        apu_valid_i = t.val;
        #1;
        check("gnt_o",         idx, 32'(gnt_o),         32'(t.e_gnt));
        check("valid_o",       idx, 32'(valid_o),       32'(t.e_val));
        check("apu_req_o",     idx, 32'(apu_req_o),     32'(t.e_req));
        check("apu_op_o",      idx, apu_op_o,           op_of(t.e_win));
        check("outstanding_o", idx, 32'(outstanding_o), 32'(t.e_out));
        check("err_o",         idx, 32'(err_o),         32'(t.e_err));
        check("apu_ready_o",   idx, 32'(apu_ready_o),   32'd1);
    endtask

    initial begin
        for (int k = 0; k < int'(NREQ); k++) op_i[k*OP_W +: OP_W] = op_of(k);
        rst_i = 1'b1; req_i = '0; apu_gnt_i = 1'b0; apu_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // round-robin fill to full, then in-order drain
        tbl[0]  = v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, -1);
        tbl[1]  = v(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0);
        tbl[2]  = v(0, 4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 1, 0, 1);
        tbl[3]  = v(0, 4'b1111, 1, 0, 4'b0100, 4'b0000, 1, 2, 0, 2);
        tbl[4]  = v(0, 4'b1111, 1, 0, 4'b1000, 4'b0000, 1, 3, 0, 3);
        tbl[5]  = v(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 4, 0, -1);
        tbl[6]  = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 4, 0, -1);
        tbl[7]  = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0010, 0, 3, 0, -1);
        tbl[8]  = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0100, 0, 2, 0, -1);
        tbl[9]  = v(0, 4'b0000, 0, 1, 4'b0000, 4'b1000, 0, 1, 0, -1);
        // stalled winner keeps priority, then pointer advances past it
        tbl[10] = v(0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        tbl[11] = v(0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        tbl[12] = v(0, 4'b0101, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        tbl[13] = v(0, 4'b0101, 1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0);
        tbl[14] = v(0, 4'b0101, 1, 0, 4'b0100, 4'b0000, 1, 1, 0, 2);
        // same-cycle accept and return routes to old head
        tbl[15] = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 2, 0, -1);
        tbl[16] = v(0, 4'b1000, 1, 1, 4'b1000, 4'b0100, 1, 1, 0, 3);
        tbl[17] = v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, -1);
        tbl[18] = v(0, 4'b0000, 0, 1, 4'b0000, 4'b1000, 0, 1, 0, -1);
        // stray response sets sticky error; accept+return on empty is not a bypass
        tbl[19] = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, -1);
        tbl[20] = v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, -1);
        tbl[21] = v(0, 4'b1111, 1, 1, 4'b0001, 4'b0000, 1, 0, 1, 0);
        tbl[22] = v(0, 4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 1, 1, 1);
        // reset mid-operation discards outstanding entries and the pointer
        tbl[23] = v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 2, 1, -1);
        tbl[24] = v(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0);
        tbl[25] = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 1, 0, -1);
        tbl[26] = v(0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, -1);
        tbl[27] = v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, -1);

        for (int i = 0; i < NVEC; i++) apply(tbl[i], i);

        // full with a returning response: request still blocked that cycle, granted the next
        hand[0] = v(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, -1);
        hand[1] = v(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0);
        hand[2] = v(0, 4'b1111, 1, 0, 4'b0010, 4'b0000, 1, 1, 0, 1);
        hand[3] = v(0, 4'b1111, 1, 0, 4'b0100, 4'b0000, 1, 2, 0, 2);
        hand[4] = v(0, 4'b1111, 1, 0, 4'b1000, 4'b0000, 1, 3, 0, 3);
        hand[5] = v(0, 4'b1111, 1, 1, 4'b0000, 4'b0001, 0, 4, 0, -1);
        hand[6] = v(0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 3, 0, 0);
        hand[7] = v(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 4, 0, -1);

        for (int i = 0; i < NHAND; i++) apply(hand[i], 100 + i);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
